// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronises SCK/MOSI/CS into sysclk, deserialises MSB-first words, strobes oRxReady.
// Optional debug bus enabled by defining SPI_BYTE_RX_PROBE_EN; otherwise probe is tied to 8'h00.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  iSPIClk,
  input  logic                  iSPIMOSI,
  input  logic                  iSPICS,
  output logic [DATA_WIDTH-1:0] oRx,
  output logic                  oRxReady,
  output logic [7:0]            probe
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] r_sck_sync  = '0;
  logic [SYNC_STAGES-1:0] r_mosi_sync = '0;
  logic [SYNC_STAGES-1:0] r_cs_sync   = '1;
  logic                   r_sck_hist  = 1'b0;

  // The MSB of the word is never needed after completion, so only DATA_WIDTH-1 bits are kept.
  logic [DATA_WIDTH-2:0]  r_shift = '0;
  logic [CNT_W-1:0]       r_count = '0;
  logic [DATA_WIDTH-1:0]  r_rx    = '0;
  logic                   r_ready = 1'b0;

  logic w_sck;
  logic w_mosi;
  logic w_cs_active;
  logic w_sck_rise;
  logic w_last_bit;

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_active = ~r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck & ~r_sck_hist;
  assign w_last_bit  = (r_count == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sck_hist  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], iSPIClk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], iSPIMOSI};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], iSPICS};
      r_sck_hist  <= w_sck;
    end
  end

  // Holding count/shift at zero while deselected both aborts partial words and
  // guarantees every CS falling edge begins a fresh word.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_shift <= '0;
      r_count <= '0;
      r_rx    <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (!w_cs_active) begin
        r_shift <= '0;
        r_count <= '0;
      end else if (w_sck_rise) begin
        r_shift <= {r_shift[DATA_WIDTH-3:0], w_mosi};
        r_count <= r_count + CNT_W'(1);
        if (w_last_bit) begin
          r_rx    <= {r_shift, w_mosi};
          r_ready <= 1'b1;
        end
      end
    end
  end

  assign oRx      = r_rx;
  assign oRxReady = r_ready;

`ifdef SPI_BYTE_RX_PROBE_EN
  logic       r_toggle = 1'b0;
  logic [7:0] r_probe  = '0;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_toggle <= 1'b0;
      r_probe  <= '0;
    end else begin
      if (w_cs_active && w_sck_rise && w_last_bit) begin
        r_toggle <= ~r_toggle;
      end
      r_probe <= {w_cs_active, w_sck, w_mosi, r_toggle, 4'(r_count)};
    end
  end

  assign probe = r_probe;
`else
  assign probe = 8'h00;
`endif

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: a queue of expected bytes drives a per-cycle output check.
module tb_spi_byte_rx;

  localparam int SYNC_STAGES = 2;
  localparam int LAT_MAX     = SYNC_STAGES + 3;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       iSPIClk  = 1'b0;
  logic       iSPIMOSI = 1'b0;
  logic       iSPICS   = 1'b1;
  logic [7:0] oRx;
  logic       oRxReady;
  logic [7:0] probe;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES), .DATA_WIDTH(8)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .iSPIClk  (iSPIClk),
    .iSPIMOSI (iSPIMOSI),
    .iSPICS   (iSPICS),
    .oRx      (oRx),
    .oRxReady (oRxReady),
    .probe    (probe)
  );

  always #5 sysclk = ~sysclk;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int strobes = 0;

  logic [7:0] exp_q[$];
  int         due_q[$];
  logic [7:0] model_rx   = 8'h00;
  logic       prev_ready = 1'b0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the expected-byte queue
  initial begin
    forever begin
      @(posedge sysclk);
      #1;
      cyc++;
      if (reset) begin
        exp_q.delete();
        due_q.delete();
        model_rx = 8'h00;
        chk(oRxReady == 1'b0, "reset_ready", int'(oRxReady), 0);
        chk(oRx == 8'h00, "reset_rx", int'(oRx), 0);
      end else if (oRxReady) begin
        strobes++;
        chk(!prev_ready, "strobe_width", int'(prev_ready), 0);
        chk(exp_q.size() != 0, "unexpected_strobe", int'(oRx), 0);
        if (exp_q.size() != 0) begin
          model_rx = exp_q.pop_front();
          void'(due_q.pop_front());
        end
        chk(oRx == model_rx, "strobe_data", int'(oRx), int'(model_rx));
      end else begin
        chk(oRx == model_rx, "rx_hold", int'(oRx), int'(model_rx));
        if (due_q.size() != 0 && (cyc - due_q[0]) > LAT_MAX) begin
          chk(1'b0, "strobe_timeout", cyc - due_q[0], LAT_MAX);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
`ifdef SPI_BYTE_RX_PROBE_EN
      if (iSPICS && dut.w_cs_active == 1'b0 && !reset)
        chk(probe[2:0] == 3'd0, "probe_count_idle", int'(probe[2:0]), 0);
`else
      chk(probe == 8'h00, "probe_tied", int'(probe), 0);
`endif
      prev_ready = oRxReady;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic cs_low();
    iSPICS = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    iSPICS = 1'b1;
    tick(8);
  endtask

  // SCK = sysclk/8: 4 cycles low (MOSI set up), 4 cycles high
  task automatic send_bits(input logic [7:0] d, input int n);
    logic [7:0] v;
    v = d;
    for (int i = 0; i < n; i++) begin
      iSPIMOSI = v[7-i];
      tick(4);
      iSPIClk = 1'b1;
      if (i == 7 && !iSPICS) begin
        exp_q.push_back(v);
        due_q.push_back(cyc);
      end
      tick(4);
      iSPIClk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bits(d, 8);
  endtask

  int s0;

  initial begin
    // Reset held 3 cycles, then idle
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);
    chk(oRx == 8'h00, "idle_rx", int'(oRx), 8'h00);
    chk(strobes == 0, "idle_strobes", strobes, 0);
    chk(probe == 8'h00, "idle_probe", int'(probe), 8'h00);

    // Single byte
    s0 = strobes;
    cs_low();
    send_byte(8'hA5);
    cs_high();
    chk(strobes - s0 == 1, "a5_strobes", strobes - s0, 1);
    chk(oRx == 8'hA5, "a5_rx", int'(oRx), 8'hA5);
    chk(model_rx == 8'hA5, "a5_model", int'(model_rx), 8'hA5);

    // Three bytes in one CS assertion
    s0 = strobes;
    cs_low();
    send_byte(8'h3C);
    send_byte(8'hFF);
    send_byte(8'h00);
    cs_high();
    chk(strobes - s0 == 3, "multi_strobes", strobes - s0, 3);
    chk(oRx == 8'h00, "multi_rx", int'(oRx), 8'h00);

    // Complete byte, aborted partial, then complete byte
    s0 = strobes;
    cs_low();
    send_byte(8'h12);
    cs_high();
    chk(oRx == 8'h12, "pre_abort_rx", int'(oRx), 8'h12);
    cs_low();
    send_bits(8'hE0, 5);
    cs_high();
    chk(oRx == 8'h12, "abort_rx", int'(oRx), 8'h12);
    chk(strobes - s0 == 1, "abort_strobes", strobes - s0, 1);
    cs_low();
    send_byte(8'h7E);
    cs_high();
    chk(oRx == 8'h7E, "after_abort_rx", int'(oRx), 8'h7E);
    chk(strobes - s0 == 2, "after_abort_strobes", strobes - s0, 2);

    // Reset mid-byte
    s0 = strobes;
    cs_low();
    send_bits(8'hF0, 4);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk(oRx == 8'h00, "post_reset_rx", int'(oRx), 8'h00);
    chk(strobes - s0 == 0, "reset_strobes", strobes - s0, 0);
    cs_high();
    cs_low();
    send_byte(8'h81);
    cs_high();
    chk(oRx == 8'h81, "after_reset_rx", int'(oRx), 8'h81);
    chk(strobes - s0 == 1, "after_reset_strobes", strobes - s0, 1);

    // SCK activity with CS high is ignored
    s0 = strobes;
    for (int i = 0; i < 16; i++) begin
      iSPIMOSI = i[0];
      iSPIClk  = ~iSPIClk;
      tick(4);
    end
    iSPIClk = 1'b0;
    tick(8);
    chk(strobes - s0 == 0, "cs_idle_strobes", strobes - s0, 0);
    chk(oRx == 8'h81, "cs_idle_rx", int'(oRx), 8'h81);
`ifdef SPI_BYTE_RX_PROBE_EN
    chk(probe[2:0] == 3'd0, "cs_idle_probe", int'(probe[2:0]), 0);
`endif
    chk(exp_q.size() == 0, "pending_strobes", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
